// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory arbiter between fetch and data ports.
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_DATA} arb_grant_t;

    localparam int LAT_W = 3;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int count_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/register.sv
// Generic enabled register with synchronous active-high reset to a constant.
module register #(
    parameter int           N     = 1,
    parameter logic [N-1:0] RESET = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET;
        else if (ena)
            q <= d;
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Serialises fetch and data accesses onto one single-ported memory.
// Data has priority; a streak limit guarantees fetch progress under data pressure.
module rv32i_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int READ_LATENCY    = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_ena,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int                    STREAK_W   = count_width(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [LAT_W-1:0]      LAT_LOAD   = LAT_W'(READ_LATENCY);
    localparam int                    REQ_W      = ADDR_W + 1 + DATA_W;

    arb_state_t           state;
    arb_grant_t           grant;
    arb_grant_t           next_grant;
    logic [LAT_W-1:0]     lat_cnt;
    logic [STREAK_W-1:0]  streak;
    logic                 fetch_forced;
    logic                 capture;
    logic                 last_access;

    logic [ADDR_W-1:0]    sel_addr;
    logic                 sel_we;
    logic [DATA_W-1:0]    sel_wdata;
    logic [ADDR_W-1:0]    lat_addr;
    logic                 lat_we;
    logic [DATA_W-1:0]    lat_wdata;
    logic [DATA_W-1:0]    rdata_q;

    // Fetch only overrides data once the data streak has reached a nonzero limit.
    always_comb begin
        fetch_forced = (MAX_DATA_STREAK != 0) && (streak == STREAK_MAX);
        next_grant   = GNT_NONE;
        sel_addr     = d_addr;
        sel_we       = d_we;
        sel_wdata    = d_wdata;
        if (if_req && (!d_req || fetch_forced)) begin
            next_grant = GNT_FETCH;
            sel_addr   = if_addr;
            sel_we     = 1'b0;
            sel_wdata  = '0;
        end else if (d_req) begin
            next_grant = GNT_DATA;
        end
    end

    assign capture     = (state == ARB_IDLE) && (next_grant != GNT_NONE);
    assign last_access = (state == ARB_ACCESS) && (lat_cnt == '0);

    register #(.N(REQ_W), .RESET('0)) u_req_latch (
        .clk (clk),
        .rst (rst),
        .ena (capture),
        .d   ({sel_addr, sel_we, sel_wdata}),
        .q   ({lat_addr, lat_we, lat_wdata})
    );

    // Stores return zero so the data port never sees stale load data.
    register #(.N(DATA_W), .RESET('0)) u_rdata_q (
        .clk (clk),
        .rst (rst),
        .ena (last_access),
        .d   (lat_we ? '0 : mem_rd_data),
        .q   (rdata_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant      <= GNT_NONE;
            lat_cnt    <= '0;
            streak     <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            mem_wr_ena <= 1'b0;
        end else begin
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            mem_wr_ena <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (capture) begin
                        state      <= ARB_ACCESS;
                        grant      <= next_grant;
                        lat_cnt    <= LAT_LOAD;
                        mem_wr_ena <= (next_grant == GNT_DATA) && d_we;
                        if (next_grant == GNT_DATA && if_req) begin
                            if (streak != STREAK_MAX)
                                streak <= streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                ARB_ACCESS: begin
                    if (lat_cnt == '0) begin
                        state    <= ARB_RESP;
                        if_valid <= (grant == GNT_FETCH);
                        d_valid  <= (grant == GNT_DATA);
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ARB_RESP: begin
                    state <= ARB_IDLE;
                    grant <= GNT_NONE;
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

    assign if_rdata    = if_valid ? rdata_q : '0;
    assign d_rdata     = d_valid  ? rdata_q : '0;
    assign mem_addr    = lat_addr;
    assign mem_wr_data = lat_wdata;

endmodule
